picosoc_slotcfg_bank: RTL

Parametrised PicoSoC iomem peripheral that stages Apple II slot card assignments in a local shadow table and commits them atomically to the slotmaker configuration port. It generalises slot count and card-ID width, adds per-slot dirty tracking, a sequencing commit engine, a live readback window and status reporting. It sits on the PicoSoC iomem bus, between the firmware and the slotmaker.

---
 rtl/picosoc_slotcfg_bank_if.sv | 27 ++
 rtl/picosoc_slotcfg_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_slotcfg_bank_if.sv
// rtl/picosoc_slotcfg_bank_if.sv - PicoSoC iomem bus bundle for the slot configuration bank
interface picosoc_slotcfg_bank_if;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_rdata,
        input  iomem_ready
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_rdata,
        output iomem_ready
    );
endinterface

// File: rtl/picosoc_slotcfg_bank.sv
// rtl/picosoc_slotcfg_bank.sv - staged Apple II slot card table with atomic commit to the slotmaker
// Optional feature macro: SLOTCFG_IRQ_EN (irq follows sticky DONE when defined, tied low otherwise).
module picosoc_slotcfg_bank #(
    parameter int          NUM_SLOTS = 8,
    parameter int          CARD_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    picosoc_slotcfg_bank_if.slave bus,
    output logic [3:0]            cfg_slot,
    output logic [CARD_W-1:0]     cfg_card,
    output logic                  cfg_wr,
    input  logic [CARD_W-1:0]     cfg_card_i,
    output logic                  irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FIN,
        S_LRD1,
        S_LRD2
    } state_t;

    localparam logic [3:0] IDX_LAST = 4'(NUM_SLOTS - 1);

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [CARD_W-1:0]   stage_q [16];
    logic [CARD_W-1:0]   stage_d [16];
    logic [15:0]         dirty_q, dirty_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [3:0]          cfg_slot_q, cfg_slot_d;
    logic [CARD_W-1:0]   cfg_card_q, cfg_card_d;
    logic                cfg_wr_q, cfg_wr_d;

    logic        sel;
    logic        is_wr;
    logic [1:0]  bank;
    logic [3:0]  n;
    logic        slot_ok;
    logic        busy;
    logic        live_rd;
    logic        stage_wr;
    logic        accept;
    logic        scan_load;
    logic [31:0] old_word;
    logic [31:0] merged;
    logic        unused_addr_bits;

    assign sel      = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign is_wr    = |bus.iomem_wstrb;
    assign bank     = bus.iomem_addr[7:6];
    assign n        = bus.iomem_addr[5:2];
    assign slot_ok  = (32'(n) < 32'(NUM_SLOTS));
    assign busy     = (state_q == S_SCAN) || (state_q == S_FIN);
    assign live_rd  = (bank == 2'd1) && slot_ok && !is_wr;
    assign stage_wr = (bank == 2'd0) && slot_ok && is_wr;

    // Stage writes and live reads wait out a commit so the scan sees a frozen table.
    assign accept = sel && !ready_q
                 && ((state_q == S_IDLE) || (busy && !(stage_wr || live_rd)));

    assign unused_addr_bits = ^bus.iomem_addr[1:0];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stage_d    = stage_q;
        dirty_d    = dirty_q;
        done_d     = done_q;
        ready_d    = 1'b0;
        rdata_d    = rdata_q;
        cfg_slot_d = cfg_slot_q;
        cfg_card_d = cfg_card_q;
        cfg_wr_d   = 1'b0;
        scan_load  = 1'b0;
        old_word   = 32'(stage_q[n]);
        merged     = old_word;

        case (state_q)
            S_SCAN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_FIN;
                end else begin
                    idx_d     = idx_q + 4'd1;
                    scan_load = 1'b1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_LRD1: begin
                rdata_d = 32'(cfg_card_i);
                ready_d = 1'b1;
                state_d = S_LRD2;
            end
            S_LRD2: begin
                state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            ready_d = 1'b1;
            rdata_d = '0;
            case (bank)
                2'd0: begin
                    if (slot_ok) begin
                        if (is_wr) begin
                            for (int b = 0; b < 4; b++) begin
                                merged[8*b +: 8] = bus.iomem_wstrb[b] ? bus.iomem_wdata[8*b +: 8]
                                                                      : old_word[8*b +: 8];
                            end
                            stage_d[n] = merged[CARD_W-1:0];
                            dirty_d[n] = 1'b1;
                        end else begin
                            rdata_d = old_word;
                        end
                    end
                end
                2'd1: begin
                    if (live_rd) begin
                        ready_d    = 1'b0;
                        state_d    = S_LRD1;
                        cfg_slot_d = n;
                    end
                end
                2'd2: begin
                    if (n == 4'd0) begin
                        if (is_wr) begin
                            if (bus.iomem_wdata[2]) begin
                                done_d = 1'b0;
                            end
                            if (!busy) begin
                                // DISCARD takes priority over a COMMIT in the same write.
                                if (bus.iomem_wdata[1]) begin
                                    dirty_d = '0;
                                end else if (bus.iomem_wdata[0]) begin
                                    if (dirty_q != 16'd0) begin
                                        state_d   = S_SCAN;
                                        idx_d     = 4'd0;
                                        scan_load = 1'b1;
                                    end else begin
                                        done_d = 1'b1;
                                    end
                                end
                            end
                        end else begin
                            rdata_d = {dirty_q, 14'd0, done_q, busy};
                        end
                    end
                end
                default: ;
            endcase
        end

        // Outputs for slot idx_d are loaded one edge early so they appear in its scan cycle.
        if (scan_load) begin
            cfg_slot_d = idx_d;
            if (dirty_q[idx_d]) begin
                cfg_wr_d       = 1'b1;
                cfg_card_d     = stage_q[idx_d];
                dirty_d[idx_d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                stage_q[i] <= '0;
            end
            dirty_q    <= 16'd0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            cfg_slot_q <= 4'd0;
            cfg_card_q <= '0;
            cfg_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
            dirty_q    <= dirty_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            cfg_slot_q <= cfg_slot_d;
            cfg_card_q <= cfg_card_d;
            cfg_wr_q   <= cfg_wr_d;
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign cfg_slot        = cfg_slot_q;
    assign cfg_card        = cfg_card_q;
    assign cfg_wr          = cfg_wr_q;

`ifdef SLOTCFG_IRQ_EN
    assign irq = done_q;
`else
    assign irq = 1'b0;
`endif

endmodule
